// File: rtl/sampler_pkg.sv
// Shared definitions for the sample compactor: default sizes, FSM state
// encoding and a lane popcount helper.
package sampler_pkg;

   localparam int unsigned LANES_DEF      = 8;
   localparam int unsigned CAND_BITS_DEF  = 16;
   localparam int unsigned N_COEFFS_DEF   = 256;
   localparam int unsigned FIFO_DEPTH_DEF = 64;
   localparam int unsigned PIPE_DEPTH_DEF = 4;

   // Widest lane vector the popcount helper accepts.
   localparam int unsigned MAX_LANES = 32;
   localparam int unsigned POP_W     = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Number of set bits in a lane mask (zero-extend narrower masks).
   function automatic logic [POP_W-1:0] popcount(input logic [MAX_LANES-1:0] v);
      logic [POP_W-1:0] n;
      n = '0;
      for (int i = 0; i < int'(MAX_LANES); i++) begin
         n = n + POP_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/sample_compactor_if.sv
// Lane input bus from the sampler plus the coefficient output handshake.
//   master : sampler/consumer side (drives lanes and coeff_ready)
//   slave  : compactor side (drives entropy_ready and the coefficient stream)
interface sample_compactor_if
   import sampler_pkg::*;
#(
   parameter int unsigned LANES     = LANES_DEF,
   parameter int unsigned CAND_BITS = CAND_BITS_DEF,
   parameter int unsigned N_COEFFS  = N_COEFFS_DEF
);
   localparam int unsigned IDX_W = $clog2(N_COEFFS);

   logic [LANES*CAND_BITS-1:0] in_vals;
   logic [LANES-1:0]           in_valid;
   logic [LANES-1:0]           in_retry;
   logic                       entropy_ready;
   logic [CAND_BITS-1:0]       coeff_out;
   logic                       coeff_valid;
   logic                       coeff_ready;
   logic [IDX_W-1:0]           coeff_index;

   modport master (
      output in_vals, in_valid, in_retry, coeff_ready,
      input  entropy_ready, coeff_out, coeff_valid, coeff_index
   );

   modport slave (
      input  in_vals, in_valid, in_retry, coeff_ready,
      output entropy_ready, coeff_out, coeff_valid, coeff_index
   );

endinterface

// File: rtl/multi_write_fifo.sv
// Circular buffer with LANES write ports per cycle and one read port.
// Ports: clk, rst (sync, high), clear (sync flush), wr_en/wr_data (lane
// masks already packed by the caller), rd_en, rd_data (head), count.
// Enabled lanes land in consecutive slots in ascending lane order; the
// caller guarantees never to enable more lanes than there are free slots.
module multi_write_fifo #(
   parameter int unsigned LANES  = 8,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic [LANES-1:0]          wr_en,
   input  logic [LANES*DATA_W-1:0]   wr_data,
   input  logic                      rd_en,
   output logic [DATA_W-1:0]         rd_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned OFF_W = $clog2(LANES + 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count_q;
   logic [PTR_W-1:0]  slot [LANES];
   logic [OFF_W-1:0]  n_wr;
   logic              rd_fire;

   // Pointer advance with wrap for any depth.
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                input logic [OFF_W-1:0] d);
      logic [PTR_W:0] s;
      s = (PTR_W+1)'(p) + (PTR_W+1)'(d);
      if (s >= (PTR_W+1)'(DEPTH)) s = s - (PTR_W+1)'(DEPTH);
      return s[PTR_W-1:0];
   endfunction

   // Prefix sum of enabled lanes gives each lane its slot offset.
   always_comb begin
      logic [OFF_W-1:0] off;
      off = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         slot[i] = ptr_add(wr_ptr, off);
         off     = off + OFF_W'(wr_en[i]);
      end
      n_wr = off;
   end

   assign rd_fire = rd_en && (count_q != '0);
   assign rd_data = mem[rd_ptr];
   assign count   = count_q;

   // Storage array; unreset, validity tracked by the pointers.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(LANES); i++) begin
         if (wr_en[i]) mem[slot[i]] <= wr_data[i*DATA_W +: DATA_W];
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         wr_ptr  <= ptr_add(wr_ptr, n_wr);
         if (rd_fire) rd_ptr <= ptr_add(rd_ptr, OFF_W'(1));
         count_q <= count_q + CNT_W'(n_wr) - CNT_W'(rd_fire);
      end
   end

endmodule

// File: rtl/sample_compactor.sv
// Packs accepted sampler lanes into a dense in-order coefficient stream of
// one polynomial (N_COEFFS entries) and throttles upstream entropy.
// Ports: clk, rst (sync, high), start, bus (lane input + coefficient
// handshake, slave side), busy, poly_done (1-cycle pulse), retry_count
// (saturating), overflow (sticky lane drop on full buffer).
module sample_compactor
   import sampler_pkg::*;
#(
   parameter int unsigned LANES      = LANES_DEF,
   parameter int unsigned CAND_BITS  = CAND_BITS_DEF,
   parameter int unsigned N_COEFFS   = N_COEFFS_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int unsigned PIPE_DEPTH = PIPE_DEPTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   sample_compactor_if.slave  bus,
   output logic               busy,
   output logic               poly_done,
   output logic [15:0]        retry_count,
   output logic               overflow
);
   localparam int unsigned IDX_W  = $clog2(N_COEFFS);
   localparam int unsigned ACC_W  = $clog2(N_COEFFS + 1);
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned THRESH = (PIPE_DEPTH + 1) * LANES;

   if (FIFO_DEPTH < THRESH) begin : g_depth_chk
      $error("FIFO_DEPTH must be at least (PIPE_DEPTH+1)*LANES");
   end
   if (LANES > MAX_LANES) begin : g_lanes_chk
      $error("LANES exceeds MAX_LANES");
   end

   state_t            state, state_nxt;
   logic [ACC_W-1:0]  acc_cnt;
   logic [IDX_W-1:0]  coeff_index;
   logic [CNT_W-1:0]  occ;
   logic [LANES-1:0]  wr_en;
   logic [CAND_BITS-1:0] rd_data;
   logic              run, pop_fire, start_fire, done_fire, drop_full;
   int unsigned       k;
   logic [16:0]       retry_sum;
   logic [15:0]       retry_nxt;

   // Lanes written this beat: k = min(accepted, room left in polynomial, free slots).
   always_comb begin
      int unsigned n_valid, room, free, lim, seen;
      run     = (state == ST_RUN);
      n_valid = 32'(popcount(MAX_LANES'(bus.in_valid)));
      room    = N_COEFFS - 32'(acc_cnt);
      free    = FIFO_DEPTH - 32'(occ);
      lim     = (n_valid < room) ? n_valid : room;
      k       = (lim < free) ? lim : free;
      if (!run) k = 0;
      // Only a shortage of buffer space counts as overflow, not the polynomial limit.
      drop_full = run && (lim > free);
      wr_en = '0;
      seen  = 0;
      for (int i = 0; i < int'(LANES); i++) begin
         if (bus.in_valid[i]) begin
            if (seen < k) wr_en[i] = 1'b1;
            seen++;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt  = state;
      start_fire = 1'b0;
      done_fire  = 1'b0;
      pop_fire   = bus.coeff_valid && bus.coeff_ready;
      unique case (state)
         ST_IDLE: begin
            // The poly_done cycle is already IDLE but must not restart.
            if (start && !poly_done) begin
               start_fire = 1'b1;
               state_nxt  = ST_RUN;
            end
         end
         ST_RUN: begin
            if (32'(acc_cnt) + k >= N_COEFFS) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (pop_fire && (coeff_index == IDX_W'(N_COEFFS - 1))) begin
               done_fire = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   assign retry_sum = 17'(retry_count) + 17'(popcount(MAX_LANES'(bus.in_retry)));
   assign retry_nxt = retry_sum[16] ? 16'hFFFF : retry_sum[15:0];

   // Per-polynomial counters and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_cnt     <= '0;
         coeff_index <= '0;
         retry_count <= '0;
         overflow    <= 1'b0;
         poly_done   <= 1'b0;
      end else begin
         poly_done <= done_fire;
         if (start_fire) begin
            acc_cnt     <= '0;
            coeff_index <= '0;
            retry_count <= '0;
            overflow    <= 1'b0;
         end else begin
            if (run) begin
               acc_cnt     <= acc_cnt + ACC_W'(k);
               retry_count <= retry_nxt;
            end
            if (pop_fire)  coeff_index <= coeff_index + IDX_W'(1);
            if (drop_full) overflow    <= 1'b1;
         end
      end
   end

   multi_write_fifo #(
      .LANES (LANES),
      .DATA_W(CAND_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .clear  (start_fire),
      .wr_en  (wr_en),
      .wr_data(bus.in_vals),
      .rd_en  (pop_fire),
      .rd_data(rd_data),
      .count  (occ)
   );

   // Throttle leaves room for every beat still in the upstream pipe.
   assign bus.entropy_ready = run && (32'(occ) + THRESH <= FIFO_DEPTH) &&
                              (32'(acc_cnt) < N_COEFFS);
   assign bus.coeff_valid   = (occ != '0);
   assign bus.coeff_out     = bus.coeff_valid ? rd_data : '0;
   assign bus.coeff_index   = coeff_index;
   assign busy              = (state != ST_IDLE);

endmodule

// File: tb/tb_sample_compactor.sv
// Directed testbench for sample_compactor: an upstream model with a 4-beat
// issue-to-arrival lag, an expected-coefficient queue and a handshake monitor.
module tb_sample_compactor;
   import sampler_pkg::*;

   localparam int unsigned LANES = 8;
   localparam int unsigned CB    = 16;
   localparam int unsigned N     = 256;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned PIPE  = 4;

   typedef struct {
      logic       act;
      logic [7:0] vmask;
      logic [7:0] rmask;
      logic [7:0] emask;   // lanes the bench expects to see on the output
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy, poly_done, overflow;
   logic [15:0] retry_count;

   sample_compactor_if #(.LANES(LANES), .CAND_BITS(CB), .N_COEFFS(N)) bus ();

   sample_compactor #(
      .LANES(LANES), .CAND_BITS(CB), .N_COEFFS(N),
      .FIFO_DEPTH(DEPTH), .PIPE_DEPTH(PIPE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bus        (bus),
      .busy       (busy),
      .poly_done  (poly_done),
      .retry_count(retry_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_mis = 0;
   int          pops = 0;
   int          done_cnt = 0;
   int          issued = 0;
   int          ser = 0;
   logic [15:0] exp_q [$];
   beat_t       pipe_q [$];
   beat_t       plan_q [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic beat_t mk_beat(input logic act, input logic [7:0] v,
                                     input logic [7:0] r, input logic [7:0] e);
      beat_t b;
      b.act = act; b.vmask = v; b.rmask = r; b.emask = e;
      return b;
   endfunction

   function automatic logic [15:0] lane_val(input int s, input int lane);
      return 16'((s << 3) | lane);
   endfunction

   task automatic drive(input beat_t b);
      if (b.act) begin
         for (int i = 0; i < int'(LANES); i++) begin
            bus.in_vals[i*CB +: CB] = lane_val(ser, i);
            if (b.emask[i]) exp_q.push_back(lane_val(ser, i));
         end
         bus.in_valid = b.vmask;
         bus.in_retry = b.rmask;
         ser++;
      end else begin
         bus.in_vals  = '0;
         bus.in_valid = '0;
         bus.in_retry = '0;
      end
   endtask

   // One clock with the upstream model: issue on entropy_ready, arrive PIPE cycles later.
   task automatic tick();
      beat_t head, nb;
      @(posedge clk);
      #1;
      head = pipe_q.pop_front();
      nb   = mk_beat(1'b0, 8'h00, 8'h00, 8'h00);
      if (bus.entropy_ready && plan_q.size() > 0) begin
         nb = plan_q.pop_front();
         issued++;
      end
      pipe_q.push_back(nb);
      drive(head);
   endtask

   // One clock driving a beat directly, ignoring entropy_ready.
   task automatic manual(input beat_t b);
      @(posedge clk);
      #1;
      drive(b);
   endtask

   task automatic plan(input int n, input logic [7:0] v, input logic [7:0] r, input logic [7:0] e);
      for (int i = 0; i < n; i++) plan_q.push_back(mk_beat(1'b1, v, r, e));
   endtask

   task automatic begin_poly();
      pops = 0; done_cnt = 0; issued = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_to_done(input int bound);
      int n = 0;
      while (poly_done !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      check_eq("done_seen", 32'(poly_done), 32'd1);
   endtask

   task automatic flush();
      plan_q.delete();
      repeat (PIPE + 2) tick();
   endtask

   // Output monitor: every handshake must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (bus.coeff_valid && bus.coeff_ready) begin
            check_eq("exp_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               check_eq("coeff_out", 32'(bus.coeff_out), 32'(exp_q.pop_front()));
               check_eq("coeff_index", 32'(bus.coeff_index), 32'(pops));
            end
            pops++;
         end
         if (poly_done) done_cnt++;
      end
   end

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_busy"},  32'(busy), 32'd0);
      check_eq({tag, "_done"},  32'(poly_done), 32'd0);
      check_eq({tag, "_retry"}, 32'(retry_count), 32'd0);
      check_eq({tag, "_ovf"},   32'(overflow), 32'd0);
      check_eq({tag, "_er"},    32'(bus.entropy_ready), 32'd0);
      check_eq({tag, "_cv"},    32'(bus.coeff_valid), 32'd0);
      check_eq({tag, "_cout"},  32'(bus.coeff_out), 32'd0);
      check_eq({tag, "_cidx"},  32'(bus.coeff_index), 32'd0);
   endtask

   task automatic end_checks(input string tag, input logic [15:0] exp_retry, input logic exp_ovf);
      check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check_eq({tag, "_pops"},     32'(pops), 32'(N));
      check_eq({tag, "_q_empty"},  32'(exp_q.size()), 32'd0);
      check_eq({tag, "_retry"},    32'(retry_count), 32'(exp_retry));
      check_eq({tag, "_ovf"},      32'(overflow), 32'(exp_ovf));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0;
      bus.in_vals = '0; bus.in_valid = '0; bus.in_retry = '0; bus.coeff_ready = 1'b0;
      for (int i = 0; i < int'(PIPE); i++) pipe_q.push_back(mk_beat(1'b0, 8'h00, 8'h00, 8'h00));
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst = 1'b0;

      // Full-rate polynomial, plus start in the poly_done cycle.
      bus.coeff_ready = 1'b1;
      plan(32, 8'hFF, 8'h00, 8'hFF);
      begin_poly();
      check_eq("full_busy", 32'(busy), 32'd1);
      check_eq("full_er", 32'(bus.entropy_ready), 32'd1);
      run_to_done(2000);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("start_in_done_busy", 32'(busy), 32'd0);
      check_eq("done_one_cycle", 32'(poly_done), 32'd0);
      end_checks("full", 16'd0, 1'b0);
      flush();

      // Sparse acceptance: lanes 0,2,5,7 kept, four retries per beat.
      plan(64, 8'hA5, 8'h5A, 8'hA5);
      begin_poly();
      run_to_done(3000);
      tick();
      end_checks("sparse", 16'd256, 1'b0);
      flush();

      // Backpressure: throttle stops issue after 8 beats, buffer fills to 64 exactly.
      bus.coeff_ready = 1'b0;
      plan(32, 8'hFF, 8'h00, 8'hFF);
      begin_poly();
      repeat (30) tick();
      check_eq("bp_issued", 32'(issued), 32'd8);
      check_eq("bp_er", 32'(bus.entropy_ready), 32'd0);
      check_eq("bp_ovf", 32'(overflow), 32'd0);
      check_eq("bp_cv", 32'(bus.coeff_valid), 32'd1);
      check_eq("bp_head", 32'(bus.coeff_out), 32'(exp_q[0]));
      bus.coeff_ready = 1'b1;
      run_to_done(2000);
      tick();
      end_checks("bp", 16'd0, 1'b0);
      flush();

      // Polynomial boundary: 252 accepted, next beat keeps lanes 0..3, later beats dropped.
      plan(31, 8'hFF, 8'h00, 8'hFF);
      plan(1, 8'h0F, 8'h00, 8'h0F);
      plan(1, 8'hFF, 8'h00, 8'h0F);
      plan(3, 8'hFF, 8'h00, 8'h00);
      begin_poly();
      run_to_done(2000);
      tick();
      end_checks("boundary", 16'd0, 1'b0);
      flush();

      // Forced overflow: nine back-to-back beats into a stalled 64-entry buffer.
      bus.coeff_ready = 1'b0;
      pops = 0; done_cnt = 0;
      start = 1'b1;
      manual(mk_beat(1'b0, 8'h00, 8'h00, 8'h00));
      start = 1'b0;
      for (int i = 0; i < 8; i++) manual(mk_beat(1'b1, 8'hFF, 8'h00, 8'hFF));
      manual(mk_beat(1'b1, 8'hFF, 8'h00, 8'h00));
      check_eq("ovf_before", 32'(overflow), 32'd0);
      manual(mk_beat(1'b0, 8'h00, 8'h00, 8'h00));
      check_eq("ovf_after", 32'(overflow), 32'd1);
      bus.coeff_ready = 1'b1;
      repeat (70) manual(mk_beat(1'b0, 8'h00, 8'h00, 8'h00));
      check_eq("ovf_pops", 32'(pops), 32'd64);
      check_eq("ovf_q_empty", 32'(exp_q.size()), 32'd0);
      check_eq("ovf_cv", 32'(bus.coeff_valid), 32'd0);
      check_eq("ovf_sticky", 32'(overflow), 32'd1);
      check_eq("ovf_busy", 32'(busy), 32'd1);

      // Mid-operation reset with buffered data, then a clean polynomial.
      bus.coeff_ready = 1'b0;
      manual(mk_beat(1'b1, 8'hFF, 8'h0F, 8'hFF));
      manual(mk_beat(1'b1, 8'hFF, 8'h00, 8'hFF));
      manual(mk_beat(1'b0, 8'h00, 8'h00, 8'h00));
      check_eq("mid_cv", 32'(bus.coeff_valid), 32'd1);
      rst = 1'b1;
      exp_q.delete();
      manual(mk_beat(1'b0, 8'h00, 8'h00, 8'h00));
      check_idle_outputs("midrst");
      rst = 1'b0;
      bus.coeff_ready = 1'b1;
      plan(32, 8'hFF, 8'h00, 8'hFF);
      begin_poly();
      check_eq("post_rst_busy", 32'(busy), 32'd1);
      run_to_done(2000);
      tick();
      end_checks("post_rst", 16'd0, 1'b0);
      flush();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
